// File: rtl/piece_drop_ctrl.sv
// -----------------------------------------------------------------------------
// piece_drop_ctrl
//
// Movement controller for the falling piece of a block-stacking game. It owns
// the current piece position, turns gravity ticks and lateral requests into
// collision-check handshakes with the board, locks the piece when it can no
// longer fall, and respawns a new piece at the top.
//
// Parameters
//   BOARD_ROWS  playfield rows (row 0 = top)
//   BOARD_COLS  playfield columns (col 0 = left)
//   SPAWN_COL   column where every new piece appears
//
// Ports
//   clk                  clock, all logic on the rising edge
//   reset                synchronous, active-high reset
//   move_sig             gravity/drop tick, may stay high for many cycles
//   left_req, right_req  single-cycle lateral move requests
//   chk_req              collision-check request (registered)
//   chk_row, chk_col     cell being checked, stable while chk_req is high
//   chk_ack              board response strobe, honoured only while chk_req=1
//   chk_blocked          target cell occupied, valid with chk_ack
//   piece_row, piece_col current piece position
//   lock_pulse           one-cycle strobe while the piece is being locked
//   game_over            sticky until reset once a spawn cell is occupied
//   busy                 high in every state except IDLE
//   chk_timeout          one-cycle strobe when a check is abandoned unanswered
//
// Build option
//   DROP_TIMEOUT_EN  when defined, a check left unanswered for 255 cycles
//                    resolves as blocked and pulses chk_timeout. When not
//                    defined, checks wait forever and chk_timeout is tied 0.
// -----------------------------------------------------------------------------
module piece_drop_ctrl #(
  parameter int BOARD_ROWS = 20,
  parameter int BOARD_COLS = 10,
  parameter int SPAWN_COL  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_sig,
  input  logic       left_req,
  input  logic       right_req,
  output logic       chk_req,
  output logic [4:0] chk_row,
  output logic [3:0] chk_col,
  input  logic       chk_ack,
  input  logic       chk_blocked,
  output logic [4:0] piece_row,
  output logic [3:0] piece_col,
  output logic       lock_pulse,
  output logic       game_over,
  output logic       busy,
  output logic       chk_timeout
);

  localparam logic [4:0] LAST_ROW = 5'(BOARD_ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(BOARD_COLS - 1);
  localparam logic [3:0] SPAWN_C  = 4'(SPAWN_COL);

  typedef enum logic [2:0] {
    S_SPAWN    = 3'd0,
    S_IDLE     = 3'd1,
    S_DOWN_CHK = 3'd2,
    S_SIDE_CHK = 3'd3,
    S_LOCK     = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  state_t state;

  // A check completes either on a genuine acknowledge (only while a request
  // is outstanding, so stray acks are ignored) or on the optional timeout,
  // which is treated exactly like a blocked answer.
  logic ack_ok;
  logic to_hit;
  logic resolve;
  logic res_blocked;

  assign ack_ok      = chk_req & chk_ack;
  assign resolve     = ack_ok | to_hit;
  assign res_blocked = ack_ok ? chk_blocked : 1'b1;

`ifdef DROP_TIMEOUT_EN
  logic [7:0] to_cnt;

  // to_cnt holds the number of completed request cycles; the 255th cycle
  // without an answer is the one where it reads 254.
  assign to_hit = chk_req & ~chk_ack & (to_cnt == 8'd254);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      chk_timeout <= 1'b0;
    end else begin
      chk_timeout <= to_hit;
      if (!chk_req || resolve) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end
`else
  assign to_hit      = 1'b0;
  assign chk_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Main controller. chk_row/chk_col are pure data and only meaningful while
  // chk_req is high, so they are loaded but never reset. The target of an
  // accepted move is parked in chk_row/chk_col and copied into the piece
  // position when the board reports the cell free.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_SPAWN;
      piece_row  <= '0;
      piece_col  <= SPAWN_C;
      chk_req    <= 1'b0;
      lock_pulse <= 1'b0;
      game_over  <= 1'b0;
      busy       <= 1'b1;
    end else begin
      lock_pulse <= 1'b0;

      case (state)
        S_SPAWN: begin
          if (!chk_req) begin
            // First cycle in SPAWN: ask whether the entry cell is free.
            chk_req <= 1'b1;
            chk_row <= '0;
            chk_col <= SPAWN_C;
          end else if (resolve) begin
            chk_req <= 1'b0;
            if (res_blocked) begin
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_IDLE: begin
          // Strict priority: only the highest-priority request present this
          // cycle is considered; the others are dropped.
          if (move_sig) begin
            busy <= 1'b1;
            if (piece_row == LAST_ROW) begin
              // Nothing below the bottom row, so lock without asking.
              state      <= S_LOCK;
              lock_pulse <= 1'b1;
            end else begin
              state   <= S_DOWN_CHK;
              chk_req <= 1'b1;
              chk_row <= piece_row + 5'd1;
              chk_col <= piece_col;
            end
          end else if (left_req) begin
            if (piece_col != 4'd0) begin
              state   <= S_SIDE_CHK;
              busy    <= 1'b1;
              chk_req <= 1'b1;
              chk_row <= piece_row;
              chk_col <= piece_col - 4'd1;
            end
          end else if (right_req) begin
            if (piece_col != LAST_COL) begin
              state   <= S_SIDE_CHK;
              busy    <= 1'b1;
              chk_req <= 1'b1;
              chk_row <= piece_row;
              chk_col <= piece_col + 4'd1;
            end
          end
        end

        S_DOWN_CHK: begin
          if (resolve) begin
            chk_req <= 1'b0;
            if (res_blocked) begin
              state      <= S_LOCK;
              lock_pulse <= 1'b1;
            end else begin
              piece_row <= chk_row;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end
          end
        end

        S_SIDE_CHK: begin
          if (resolve) begin
            chk_req <= 1'b0;
            if (!res_blocked) begin
              piece_col <= chk_col;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_LOCK: begin
          // lock_pulse is high for this one cycle with the locked position
          // still visible; afterwards the next piece starts at the top.
          piece_row <= '0;
          piece_col <= SPAWN_C;
          state     <= S_SPAWN;
        end

        S_OVER: begin
          // Terminal until reset; every input is ignored.
        end

        default: begin
          state     <= S_SPAWN;
          piece_row <= '0;
          piece_col <= SPAWN_C;
          chk_req   <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

  // Position must stay on the board and a pending check must not move.
  a_row_range: assert property (@(posedge clk) disable iff (reset)
    piece_row <= LAST_ROW);
  a_col_range: assert property (@(posedge clk) disable iff (reset)
    piece_col <= LAST_COL);
  a_chk_stable: assert property (@(posedge clk) disable iff (reset)
    (chk_req && !resolve) |=> (chk_req && $stable(chk_row) && $stable(chk_col)));

endmodule

// File: doc/piece_drop_ctrl.md
PIECE_DROP_CTRL -- requirements
Module: piece_drop_ctrl

Interface
REQ-001 SHALL have parameter BOARD_ROWS, default 20, number of playfield rows (row 0 = top).
REQ-002 SHALL have parameter BOARD_COLS, default 10, number of playfield columns (col 0 = left).
REQ-003 SHALL have parameter SPAWN_COL, default 4, column at which each new piece appears.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port move_sig  in  1  gravity/drop tick from the auto-down timer; may stay high for many cycles.
REQ-007 SHALL have ports left_req, right_req  in  1 each  single-cycle lateral move requests.
REQ-008 SHALL have ports chk_req out 1, chk_row out 5, chk_col out 4  collision-check request and target cell.
REQ-009 SHALL have ports chk_ack in 1, chk_blocked in 1  board response; chk_blocked valid only when chk_ack=1.
REQ-010 SHALL have ports piece_row out 5, piece_col out 4  current piece position.
REQ-011 SHALL have ports lock_pulse out 1, game_over out 1, busy out 1, chk_timeout out 1.

Function
REQ-012 SHALL implement states SPAWN, IDLE, DOWN_CHK, SIDE_CHK, LOCK, OVER.
REQ-013 SPAWN SHALL request a check at (0, SPAWN_COL); blocked -> OVER, free -> IDLE.
REQ-014 IDLE SHALL accept one request per cycle, priority move_sig > left_req > right_req; requests in any other state SHALL be dropped.
REQ-015 Accepted down with piece_row = BOARD_ROWS-1 SHALL go to LOCK directly without a check.
REQ-016 Accepted down otherwise SHALL enter DOWN_CHK targeting (piece_row+1, piece_col).
REQ-017 left_req at piece_col = 0 or right_req at piece_col = BOARD_COLS-1 SHALL be ignored (stay IDLE); otherwise SIDE_CHK targets (piece_row, piece_col-/+1).
REQ-018 chk_req SHALL rise the cycle after acceptance, hold chk_row/chk_col stable, and stay high through the cycle chk_ack=1; it SHALL be low the following cycle.
REQ-019 chk_ack while chk_req=0 SHALL be ignored.
REQ-020 DOWN_CHK free -> piece_row+1 visible the cycle after ack, return IDLE; blocked -> LOCK.
REQ-021 SIDE_CHK free -> piece_col updated the cycle after ack; blocked -> position unchanged; both return IDLE.
REQ-022 LOCK SHALL assert lock_pulse for exactly one cycle with piece_row/piece_col holding the locked position, then load row 0, col SPAWN_COL and enter SPAWN.
REQ-023 OVER SHALL hold game_over=1 and ignore all inputs until reset.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 piece_row/piece_col SHALL never leave [0,BOARD_ROWS-1] x [0,BOARD_COLS-1].

Reset
REQ-026 With reset=1 at a posedge: state SPAWN, piece_row=0, piece_col=SPAWN_COL, chk_req=0, lock_pulse=0, game_over=0, chk_timeout=0, busy=1.
REQ-027 Reset mid-handshake SHALL abandon the check; a coincident chk_ack SHALL have no effect.

Configuration
REQ-028 Macro DROP_TIMEOUT_EN defined: an 8-bit counter SHALL run while chk_req=1; at 255 cycles without ack the check SHALL resolve as blocked and chk_timeout SHALL pulse one cycle.
REQ-029 Macro DROP_TIMEOUT_EN undefined: checks SHALL wait indefinitely and chk_timeout SHALL be constant 0.

Verification
REQ-030 Reset, ack spawn free in 2 cycles -> IDLE, position (0,4), busy=0, game_over=0.
REQ-031 move_sig held high 5 cycles, each check acked free in 1 cycle -> piece_row increments once per completed check, no skipped or double steps.
REQ-032 Piece at (19,4), move_sig pulse -> no chk_req, lock_pulse one cycle at (19,4), then SPAWN check at (0,4).
REQ-033 piece_col=0, left_req -> ignored; move_sig and right_req same cycle -> only DOWN_CHK issued.
REQ-034 Spawn check acked blocked -> game_over=1 sticky until reset; move_sig ignored.
REQ-035 DROP_TIMEOUT_EN defined, no ack -> chk_timeout pulse after 255 request cycles, down treated as blocked -> lock_pulse.
